// File: rtl/dtw_result_filter.sv
// Result filter behind the DTW core: drains 3-word records (qid, position, cost) from the
// sink FIFO, flags hits against a threshold and re-emits each record as a 3-beat AXI-Stream packet.
// Optional hit/drop statistics counters are built when RESULT_STATS_EN is defined.
module dtw_result_filter #(
    parameter int WIDTH      = 16,
    parameter int AXIS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  res_fifo_rden,
    input  logic                  res_fifo_empty,
    input  logic [AXIS_WIDTH-1:0] res_fifo_data,
    input  logic [WIDTH-1:0]      threshold,
    input  logic                  drop_miss,
    input  logic                  resync,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
`ifdef RESULT_STATS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           drop_count,
`endif
    output logic [31:0]           rec_count
);

    typedef enum logic [2:0] {
        RD_QID,
        RD_POS,
        RD_VAL,
        OUT0,
        OUT1,
        OUT2
    } state_t;

    state_t                state;
    logic [AXIS_WIDTH-1:0] qid_q;
    logic [AXIS_WIDTH-1:0] pos_q;
    logic [WIDTH-1:0]      cost_q;
    logic                  hit_q;

    logic                  in_read;
    logic                  hit_now;
    logic                  handshake;
    logic [AXIS_WIDTH-1:0] last_beat;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        in_read       = 1'b0;
        hit_now       = 1'b0;
        handshake     = 1'b0;
        last_beat     = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;

        in_read       = (state == RD_QID) || (state == RD_POS) || (state == RD_VAL);
        hit_now       = (res_fifo_data[WIDTH-1:0] <= threshold);
        m_axis_tvalid = (state == OUT0) || (state == OUT1) || (state == OUT2);
        handshake     = m_axis_tvalid && m_axis_tready;

        last_beat[WIDTH-1:0]      = cost_q;
        last_beat[AXIS_WIDTH-1]   = hit_q;

        case (state)
            OUT0:    m_axis_tdata = qid_q;
            OUT1:    m_axis_tdata = pos_q;
            OUT2: begin
                m_axis_tdata = last_beat;
                m_axis_tlast = 1'b1;
            end
            default: m_axis_tdata = '0;
        endcase
    end

    assign res_fifo_rden = in_read && !res_fifo_empty;
    assign busy          = (state != RD_QID);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RD_QID;
            qid_q     <= '0;
            pos_q     <= '0;
            cost_q    <= '0;
            hit_q     <= 1'b0;
            rec_count <= '0;
        end else if (resync) begin
            // Restart wins over any pop or handshake this cycle; a popped word is discarded.
            state <= RD_QID;
        end else begin
            case (state)
                RD_QID: if (!res_fifo_empty) begin
                    qid_q <= res_fifo_data;
                    state <= RD_POS;
                end
                RD_POS: if (!res_fifo_empty) begin
                    pos_q <= res_fifo_data;
                    state <= RD_VAL;
                end
                RD_VAL: if (!res_fifo_empty) begin
                    cost_q    <= res_fifo_data[WIDTH-1:0];
                    hit_q     <= hit_now;
                    rec_count <= rec_count + 32'd1;
                    state     <= (drop_miss && !hit_now) ? RD_QID : OUT0;
                end
                OUT0:    if (handshake) state <= OUT1;
                OUT1:    if (handshake) state <= OUT2;
                OUT2:    if (handshake) state <= RD_QID;
                default: state <= RD_QID;
            endcase
        end
    end

`ifdef RESULT_STATS_EN
    logic cost_pop;

    assign cost_pop = (state == RD_VAL) && !res_fifo_empty && !resync;

    // Saturating counters; resync restarts parsing but keeps the statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            drop_count <= '0;
        end else if (cost_pop) begin
            if (hit_now && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'd1;
            if (!hit_now && drop_miss && (drop_count != 32'hFFFF_FFFF))
                drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtw_result_filter.sv
// Directed scoreboard bench for dtw_result_filter: a FIFO model feeds records, expected beats
// are queued at stimulus time and a negedge monitor checks every handshake and stall.
module tb_dtw_result_filter;

    localparam int WIDTH      = 16;
    localparam int AXIS_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  res_fifo_rden;
    logic                  res_fifo_empty;
    logic [AXIS_WIDTH-1:0] res_fifo_data;
    logic [WIDTH-1:0]      threshold = 16'd60;
    logic                  drop_miss = 1'b0;
    logic                  resync = 1'b0;
    logic [AXIS_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready = 1'b1;
    logic                  m_axis_tlast;
    logic                  busy;
    logic [31:0]           rec_count;
`ifdef RESULT_STATS_EN
    logic [31:0]           hit_count;
    logic [31:0]           drop_count;
`endif

    dtw_result_filter #(.WIDTH(WIDTH), .AXIS_WIDTH(AXIS_WIDTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .res_fifo_rden  (res_fifo_rden),
        .res_fifo_empty (res_fifo_empty),
        .res_fifo_data  (res_fifo_data),
        .threshold      (threshold),
        .drop_miss      (drop_miss),
        .resync         (resync),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy),
`ifdef RESULT_STATS_EN
        .hit_count      (hit_count),
        .drop_count     (drop_count),
`endif
        .rec_count      (rec_count)
    );

    always #5 clk = ~clk;

    // First-word-fall-through FIFO model.
    logic [31:0] fifo_mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pop_cnt = 0;

    assign res_fifo_empty = (wr_ptr == rd_ptr);
    assign res_fifo_data  = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        if (res_fifo_rden) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int out_pops = 0;
    int exp_rec = 0;
    logic [32:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, the handshake completes on the following rising edge.
    logic        stall = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_tvalid", m_axis_tvalid, 1);
                check("hold_tdata", m_axis_tdata, held_data);
                check("hold_tlast", m_axis_tlast, held_last);
            end
            if (m_axis_tvalid && res_fifo_rden)
                out_pops++;
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", m_axis_tdata);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    check("beat_tdata", m_axis_tdata, e[31:0]);
                    check("beat_tlast", m_axis_tlast, e[32]);
                end
            end
            stall     = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic push_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] c);
        push_word(q);
        push_word(p);
        push_word(c);
        exp_rec++;
    endtask

    task automatic exp_pkt(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        sb.push_back({1'b0, b0});
        sb.push_back({1'b0, b1});
        sb.push_back({1'b1, b2});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (n < 300 && !(sb.size() == 0 && !busy && wr_ptr == rd_ptr)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, (n < 300), 1);
        repeat (4) @(negedge clk);
        tick();
    endtask

    task automatic wait_tvalid(input string name);
        int n = 0;
        @(negedge clk);
        while (n < 100 && !m_axis_tvalid) begin
            @(negedge clk);
            n++;
        end
        check({name, "_tvalid_seen"}, (n < 100), 1);
    endtask

    initial begin
        int base;
        int n;
        int hs_base;
        logic tr_pat [7];
        tr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rden", res_fifo_rden, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_rec_count", rec_count, 0);
        rst_n = 1'b1;
        tick();

        // Basic hit and first-beat latency.
        base = pop_cnt;
        exp_pkt(32'd7, 32'd100, 32'h8000_0032);
        push_rec(32'd7, 32'd100, 32'd50);
        n = 0;
        @(negedge clk);
        while (n < 50 && pop_cnt < base + 3) begin
            @(negedge clk);
            n++;
        end
        check("lat_pops", pop_cnt, base + 3);
        check("lat_tvalid", m_axis_tvalid, 1);
        check("lat_rec_count", rec_count, 1);
        wait_idle("hit");
        check("hit_rec_count", rec_count, exp_rec);

        // Miss, then miss with drop.
        exp_pkt(32'd9, 32'd200, 32'h0000_0050);
        push_rec(32'd9, 32'd200, 32'd80);
        wait_idle("miss");
        drop_miss = 1'b1;
        hs_base = hs_cnt;
        push_rec(32'd9, 32'd200, 32'd80);
        wait_idle("drop");
        check("drop_no_beats", hs_cnt, hs_base);
        check("drop_rec_count", rec_count, exp_rec);
        drop_miss = 1'b0;

        // Backpressure pattern across beats.
        m_axis_tready = 1'b0;
        hs_base = hs_cnt;
        exp_pkt(32'd7, 32'd100, 32'h8000_0032);
        push_rec(32'd7, 32'd100, 32'd50);
        wait_tvalid("bp");
        for (int i = 0; i < 7; i++) begin
            tick();
            m_axis_tready = tr_pat[i];
        end
        tick();
        m_axis_tready = 1'b1;
        wait_idle("bp");
        check("bp_handshakes", hs_cnt, hs_base + 3);

        // FIFO underflow while waiting for the cost word.
        push_word(32'd11);
        push_word(32'd22);
        repeat (10) tick();
        check("stall_busy", busy, 1);
        check("stall_rden", res_fifo_rden, 0);
        check("stall_tvalid", m_axis_tvalid, 0);
        exp_pkt(32'd11, 32'd22, 32'h8000_0021);
        push_word(32'd33);
        exp_rec++;
        wait_idle("late_cost");

        // Resync while a stale qid is held.
        push_word(32'd99);
        repeat (3) tick();
        check("resync_pre_busy", busy, 1);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        check("resync_busy", busy, 0);
        exp_pkt(32'd3, 32'd4, 32'h8000_0005);
        push_rec(32'd3, 32'd4, 32'd5);
        wait_idle("resync");
        check("resync_rec_count", rec_count, exp_rec);

        // Threshold boundaries and ignored upper cost bits.
        threshold = 16'd0;
        exp_pkt(32'd40, 32'd41, 32'h8000_0000);
        push_rec(32'd40, 32'd41, 32'd0);
        exp_pkt(32'd42, 32'd43, 32'h0000_0001);
        push_rec(32'd42, 32'd43, 32'd1);
        wait_idle("th_zero");
        threshold = 16'hFFFF;
        exp_pkt(32'd44, 32'd45, 32'h8000_FFFF);
        push_rec(32'd44, 32'd45, 32'h0000_FFFF);
        wait_idle("th_ones");
        threshold = 16'd60;
        exp_pkt(32'd46, 32'd47, 32'h8000_0010);
        push_rec(32'd46, 32'd47, 32'hABCD_0010);
        wait_idle("upper_bits");
        check("bound_rec_count", rec_count, exp_rec);
`ifdef RESULT_STATS_EN
        check("stats_hit_count", hit_count, 7);
        check("stats_drop_count", drop_count, 1);
`endif

        // Reset in OUT1 under backpressure.
        m_axis_tready = 1'b0;
        exp_pkt(32'd7, 32'd100, 32'h8000_0032);
        push_rec(32'd7, 32'd100, 32'd50);
        wait_tvalid("rst_mid");
        tick();
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        tick();
        check("rst_mid_in_out1", m_axis_tdata, 100);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tvalid", m_axis_tvalid, 0);
        check("rst_mid_rec_count", rec_count, 0);
        check("rst_mid_busy", busy, 0);
        sb.delete();
        exp_rec = 0;
        tick();
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check("rst_mid_quiet", m_axis_tvalid, 0);
        exp_pkt(32'd7, 32'd100, 32'h8000_0032);
        push_rec(32'd7, 32'd100, 32'd50);
        wait_idle("post_rst");
        check("post_rst_rec_count", rec_count, exp_rec);
`ifdef RESULT_STATS_EN
        check("post_rst_hit_count", hit_count, 1);
        check("post_rst_drop_count", drop_count, 0);
`endif

        check("no_pops_in_out", out_pops, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
